pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL: clk  in  1  rising-edge clock.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: rs1_d, rs2_d  in  5 each  decode-stage source registers.
REQ-004 SHALL: rs1_e, rs2_e, rd_e  in  5 each  execute-stage register fields.
REQ-005 SHALL: memread_e, regwrite_e, br_taken_e  in  1 each  execute control (load, writes reg, redirect).
REQ-006 SHALL: rd_m, regwrite_m  in  5/1  memory-stage dest and write enable.
REQ-007 SHALL: rd_w, regwrite_w  in  5/1  writeback-stage dest and write enable.
REQ-008 SHALL: imem_req, imem_resp  in  1 each  fetch request issued / response valid.
REQ-009 SHALL: dmem_req, dmem_resp  in  1 each  data request issued / response valid.
REQ-010 SHALL: stall_f, stall_d, stall_e, stall_m  out  1 each  hold the corresponding pipeline register (stall_e drives idex.stall).
REQ-011 SHALL: flush_d, flush_e  out  1 each  load bubble (commit=0, all control zero) into IF/ID or ID/EX.
REQ-012 SHALL: imem_drop  out  1  discard the imem response in the current cycle.
REQ-013 SHALL: fwd_a, fwd_b  out  2 each  operand select: 00 regfile, 10 MEM result, 01 WB result.
REQ-014 SHALL: stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-015 SHALL: track imem_pend and dmem_pend flags: set on req when the response is not in the same cycle; clear on resp.
REQ-016 SHALL: treat dmem_wait = (dmem_pend | dmem_req) & ~dmem_resp as the highest priority condition.
REQ-017 SHALL: on dmem_wait, assert stall_f, stall_d, stall_e and stall_m; assert no flush; ignore br_taken_e and load-use that cycle.
REQ-018 SHALL: load-use = memread_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
REQ-019 SHALL: on load-use without dmem_wait, assert stall_f, stall_d and flush_e for exactly 1 cycle.
REQ-020 SHALL: on br_taken_e without dmem_wait, assert flush_d and flush_e and no stall, overriding load-use in that cycle.
REQ-021 SHALL: on imem_wait = (imem_pend | imem_req) & ~imem_resp (no dmem_wait, no branch), assert stall_f and flush_d.
REQ-022 SHALL: on br_taken_e while imem_pend=1 and imem_resp=0, set drop_pend; the next imem_resp asserts imem_drop and clears drop_pend.
REQ-023 SHALL: if br_taken_e occurs in the same cycle as imem_resp, assert imem_drop combinationally and leave drop_pend clear.
REQ-024 SHALL: while imem_drop=1, keep stall_f and flush_d asserted.
REQ-025 SHALL: a second br_taken_e while drop_pend=1 keeps a single pending drop.
REQ-026 SHALL: fwd_a = 10 if regwrite_m & rd_m!=0 & rd_m==rs1_e; else 01 if regwrite_w & rd_w!=0 & rd_w==rs1_e; else 00. fwd_b uses the same rule with rs2_e.
REQ-027 SHALL: the forwarding rule is purely combinational, with MEM taking priority over WB.
REQ-028 SHALL: stall_cnt increments by 1 each cycle stall_f=1; flush_cnt increments by 1 each cycle flush_e=1.
REQ-029 SHALL: both counters wrap modulo 2^32.
REQ-030 SHALL: derive all stall/flush outputs combinationally from the current inputs and state (zero latency).
REQ-031 SHALL: a flag update and its effect on the outputs apply from the next cycle.

Reset
REQ-032 SHALL: on rst, clear imem_pend, dmem_pend, drop_pend, stall_cnt and flush_cnt to 0 on the next edge.
REQ-033 SHALL: with rst high, drive all stall/flush/imem_drop outputs to 0 and fwd_a/fwd_b to 00.
REQ-034 SHALL: rst asserted mid-wait abandons pending state; no drop is carried across reset.

Structure
REQ-035 SHALL: place fwd_sel_t (REG=00, WB=01, MEM=10) in the shared package rv32i_types.
REQ-036 SHALL: implement REQ-026 once as sub-module fwd_sel, instantiated twice (operands a and b).
REQ-037 SHALL: the top level contains only the pending flags, the priority logic and the counters.

Verification
REQ-038 SHALL: load-use -- memread_e=1, rd_e=5, rs1_d=5 -> stall_f=stall_d=flush_e=1 for 1 cycle; stall_cnt+1, flush_cnt+1.
REQ-039 SHALL: x0 exclusion -- memread_e=1, rd_e=0, rs2_d=0 -> no stall.
REQ-040 SHALL: dmem wait -- dmem_req=1, dmem_resp=1 after 3 cycles, br_taken_e=1 during the wait -> all four stalls=1 for 3 cycles, no flush; stall_cnt+3.
REQ-041 SHALL: branch during fetch -- imem_req, then br_taken_e one cycle later, imem_resp 2 cycles after that -> flush_d=flush_e=1 on the branch cycle; imem_drop=1 exactly on the response cycle.
REQ-042 SHALL: forwarding priority -- rd_m=rd_w=7, both regwrite=1, rs1_e=7, rs2_e=3 -> fwd_a=10, fwd_b=00; with regwrite_m=0 -> fwd_a=01.
REQ-043 SHALL: reset mid-wait -- rst during dmem_pend=1 -> outputs 0 next cycle; counters 0; no stall after reset with no request.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: operand forwarding source encoding.
package rv32i_types;

    typedef enum logic [1:0] {
        REG = 2'b00,
        WB  = 2'b01,
        MEM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one EX source register; MEM beats WB, x0 never forwards.
module fwd_sel
    import rv32i_types::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       regwrite_m,
    input  logic [4:0] rd_w,
    input  logic       regwrite_w,
    output logic [1:0] sel
);

    logic w_hit_m;
    logic w_hit_w;
    fwd_sel_t w_sel;

    assign w_hit_m = regwrite_m && (rd_m != 5'd0) && (rd_m == rs_e);
    assign w_hit_w = regwrite_w && (rd_w != 5'd0) && (rd_w == rs_e);

    always_comb begin
        w_sel = REG;
        if (w_hit_m)
            w_sel = MEM;
        else if (w_hit_w)
            w_sel = WB;
    end

    assign sel = w_sel;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait tracking, stall/flush priority,
// wrong-path fetch drop and stall/flush performance counters.
module pipe_ctrl
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rs1_e,
    input  logic [4:0]  rs2_e,
    input  logic [4:0]  rd_e,
    input  logic        memread_e,
    input  logic        regwrite_e,
    input  logic        br_taken_e,
    input  logic [4:0]  rd_m,
    input  logic        regwrite_m,
    input  logic [4:0]  rd_w,
    input  logic        regwrite_w,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        imem_drop,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic        r_imem_pend;
    logic        r_dmem_pend;
    logic        r_drop_pend;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    logic       w_dmem_wait;
    logic       w_imem_wait;
    logic       w_load_use;
    logic       w_br;
    logic       w_drop;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    // regwrite_e plays no part in any hazard rule; kept on the port for interface completeness
    logic       w_unused;

    assign w_unused = regwrite_e;

    assign w_dmem_wait = (r_dmem_pend | dmem_req) & ~dmem_resp;
    assign w_imem_wait = (r_imem_pend | imem_req) & ~imem_resp;
    assign w_load_use  = memread_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    // A branch is held in EX while data memory stalls, so it only counts once the wait ends
    assign w_br        = br_taken_e & ~w_dmem_wait;
    assign w_drop      = imem_resp & (r_drop_pend | w_br);

    fwd_sel u_fwd_a (
        .rs_e       (rs1_e),
        .rd_m       (rd_m),
        .regwrite_m (regwrite_m),
        .rd_w       (rd_w),
        .regwrite_w (regwrite_w),
        .sel        (w_fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs_e       (rs2_e),
        .rd_m       (rd_m),
        .regwrite_m (regwrite_m),
        .rd_w       (rd_w),
        .regwrite_w (regwrite_w),
        .sel        (w_fwd_b)
    );

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        imem_drop = 1'b0;
        fwd_a     = REG;
        fwd_b     = REG;
        if (!rst) begin
            imem_drop = w_drop;
            fwd_a     = w_fwd_a;
            fwd_b     = w_fwd_b;
            if (w_dmem_wait) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
            end else begin
                if (w_br) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (w_load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end else if (w_imem_wait) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
                // The discarded response must not advance fetch or reach decode
                if (w_drop) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_imem_pend <= 1'b0;
            r_dmem_pend <= 1'b0;
            r_drop_pend <= 1'b0;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (imem_resp)
                r_imem_pend <= 1'b0;
            else if (imem_req)
                r_imem_pend <= 1'b1;

            if (dmem_resp)
                r_dmem_pend <= 1'b0;
            else if (dmem_req)
                r_dmem_pend <= 1'b1;

            // Only one fetch can be outstanding, so repeated branches still mean one drop
            if (imem_resp)
                r_drop_pend <= 1'b0;
            else if (w_br && r_imem_pend)
                r_drop_pend <= 1'b1;

            r_stall_cnt <= r_stall_cnt + {31'd0, stall_f};
            r_flush_cnt <= r_flush_cnt + {31'd0, flush_e};
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
